// File: rtl/ex_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_arbiter
// Purpose  : Shares one EX-stage ALU between two issue lanes. A round-robin
//            arbiter grants at most one request per cycle. The granted
//            operation is computed and held in a one-entry result register
//            together with its source lane, tag and illegal-code flag.
// Ports    : clk, rst              - clock, async active-high reset
//            in_valid0/1           - lane request valid
//            out_ready0/1          - lane request accepted this cycle
//            in_ALUFun0/1          - 4-bit ALU function per lane
//            in_dataA0/1           - operand A (shift amount in [4:0])
//            in_dataB0/1           - operand B
//            in_tag0/1             - request tag
//            out_valid / in_ready  - result handshake toward MEM/writeback
//            out_result, out_src,
//            out_tag, out_illegal  - registered result fields
//            out_gnt_cnt0/1        - saturating per-lane grant counters
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid0,
  output logic             out_ready0,
  input  logic [3:0]       in_ALUFun0,
  input  logic [31:0]      in_dataA0,
  input  logic [31:0]      in_dataB0,
  input  logic [TAG_W-1:0] in_tag0,
  input  logic             in_valid1,
  output logic             out_ready1,
  input  logic [3:0]       in_ALUFun1,
  input  logic [31:0]      in_dataA1,
  input  logic [31:0]      in_dataB1,
  input  logic [TAG_W-1:0] in_tag1,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [31:0]      out_result,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] out_gnt_cnt0,
  output logic [CNT_W-1:0] out_gnt_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Priority pointer: lane that wins when both lanes request together.
  logic             ptr;
  logic             slot_free;
  logic             gnt0;
  logic             gnt1;
  logic             accept0;
  logic             accept1;
  logic             accept;
  logic [3:0]       sel_fun;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      alu_result;
  logic             alu_illegal;

  assign slot_free = !out_valid || in_ready;
  assign gnt0      = in_valid0 && (!in_valid1 || !ptr);
  assign gnt1      = in_valid1 && (!in_valid0 || ptr);

  // Readies are forced low during reset so no requester sees a handshake
  // that the register will never capture.
  assign out_ready0 = gnt0 && slot_free && !rst;
  assign out_ready1 = gnt1 && slot_free && !rst;

  assign accept0 = in_valid0 && out_ready0;
  assign accept1 = in_valid1 && out_ready1;
  assign accept  = accept0 || accept1;

  // Operand mux: grants are one-hot, so selecting on lane 1 is sufficient.
  assign sel_fun = accept1 ? in_ALUFun1 : in_ALUFun0;
  assign sel_a   = accept1 ? in_dataA1  : in_dataA0;
  assign sel_b   = accept1 ? in_dataB1  : in_dataB0;
  assign sel_tag = accept1 ? in_tag1    : in_tag0;

  always_comb begin
    alu_result  = 32'h0;
    alu_illegal = 1'b0;
    case (sel_fun)
      4'b0000, 4'b0010: alu_result = sel_a + sel_b;
      4'b0001, 4'b0011: alu_result = sel_a - sel_b;
      4'b0100:          alu_result = sel_a & sel_b;
      4'b0101:          alu_result = sel_a | sel_b;
      4'b0110:          alu_result = sel_a ^ sel_b;
      4'b1000:          alu_result = sel_b << sel_a[4:0];
      4'b1001:          alu_result = sel_b >> sel_a[4:0];
      4'b1010:          alu_result = {sel_b[15:0], 16'h0000};
      4'b1100:          alu_result = {31'h0, (sel_a < sel_b)};
      default: begin
        alu_result  = 32'h0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  // Result register: reload on accept (also covers pop+accept in one cycle),
  // otherwise drain on pop. Fields are left untouched when not loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= 32'h0;
      out_src     <= 1'b0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      ptr         <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_src     <= accept1;
      out_tag     <= sel_tag;
      out_illegal <= alu_illegal;
      ptr         <= !accept1;
    end else if (in_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_gnt_cnt0 <= '0;
      out_gnt_cnt1 <= '0;
    end else begin
      if (accept0 && (out_gnt_cnt0 != CNT_MAX)) begin
        out_gnt_cnt0 <= out_gnt_cnt0 + 1'b1;
      end
      if (accept1 && (out_gnt_cnt1 != CNT_MAX)) begin
        out_gnt_cnt1 <= out_gnt_cnt1 + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
